// File: rtl/proc_pkg.sv
// Shared processor package for the bit-field read path.
//  WORD_SIZE   : data width in bits
//  POS_W       : width of pos/len fields; 2**POS_W > WORD_SIZE
//  bfe_state_t : bit_field_extract sequencing states
//  clamp_pos() : limits a start position to WORD_SIZE (the shift count)
package proc_pkg;

  localparam int WORD_SIZE = 8;
  localparam int POS_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MASK  = 2'd2,
    DONE  = 2'd3
  } bfe_state_t;

  // A position at or beyond the word width behaves as a full-word shift.
  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] p);
    return (p > POS_W'(WORD_SIZE)) ? POS_W'(WORD_SIZE) : p;
  endfunction

endpackage

// File: rtl/bit_field_extract_if.sv
// Request/response bus of the bit-field extractor.
//  master : requester side (drives flush, request fields and rsp_ready)
//  slave  : extractor side (drives req_ready, rsp_valid, field and flags)
//  flush         sync abort of the current operation
//  req_valid/req_ready, reg_in, pos, len          request channel
//  rsp_valid/rsp_ready, field_out, *_flag          response channel
interface bit_field_extract_if;
  import proc_pkg::*;

  logic                 flush;
  logic                 req_valid;
  logic                 req_ready;
  logic [WORD_SIZE-1:0] reg_in;
  logic [POS_W-1:0]     pos;
  logic [POS_W-1:0]     len;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] field_out;
  logic                 zero_flag;
  logic                 carry_flag;
  logic                 overflow_flag;

  modport master (
    output flush, req_valid, reg_in, pos, len, rsp_ready,
    input  req_ready, rsp_valid, field_out, zero_flag, carry_flag, overflow_flag
  );

  modport slave (
    input  flush, req_valid, reg_in, pos, len, rsp_ready,
    output req_ready, rsp_valid, field_out, zero_flag, carry_flag, overflow_flag
  );

endinterface

// File: rtl/field_mask_gen.sv
// Combinational field masker: keeps the low len bits of data.
//  len   in  POS_W      field width; 0 = empty, >= WORD_SIZE = whole word
//  data  in  WORD_SIZE  already right-shifted source word
//  field out WORD_SIZE  masked (and optionally sign-filled) field
// Build option: SIGN_EXTEND_EN -- when defined, a field of width 1..WORD_SIZE-1
// whose top bit is set has all bits above it filled with ones.
module field_mask_gen
  import proc_pkg::*;
(
  input  logic [POS_W-1:0]     len,
  input  logic [WORD_SIZE-1:0] data,
  output logic [WORD_SIZE-1:0] field
);

  logic [WORD_SIZE-1:0] mask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mask = '1;
    if (len < POS_W'(WORD_SIZE)) begin
      mask = (WORD_SIZE'(1) << len) - WORD_SIZE'(1);
    end
  end

`ifdef SIGN_EXTEND_EN
  logic sign;

  always_comb begin
    sign = 1'b0;
    // Top bit of the field is data[len-1]; only widths below the word size extend.
    for (int i = 0; i < WORD_SIZE - 1; i++) begin
      if (len == POS_W'(i + 1)) sign = data[i];
    end
    field = data & mask;
    if (sign) field = field | ~mask;
  end
`else
  assign field = data & mask;
`endif

endmodule

// File: rtl/bit_field_extract.sv
// Multi-cycle bit-field reader. Accepts a word, start position and length,
// shifts the word right one bit per cycle, masks to the field length and
// returns the field with zero/carry/overflow flags.
//  clk    in  single clock, rising edge
//  reset  in  asynchronous, active-low
//  bus    bit_field_extract_if.slave (request, response, flush)
// Build option: SIGN_EXTEND_EN (see field_mask_gen).
// Response outputs are registered out of DONE, so rsp_valid rises one edge
// after DONE is entered: eff_pos + 2 edges after the accept edge.
module bit_field_extract
  import proc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  bit_field_extract_if.slave  bus
);

  bfe_state_t           state, state_nxt;
  logic [WORD_SIZE-1:0] sh;
  logic [POS_W-1:0]     pos_q, len_q, cnt, cnt_nxt, eff_pos;
  logic                 carry_q, zero_q, ovf_q;
  logic [WORD_SIZE-1:0] field_q, field_mask;
  logic [POS_W:0]       span;
  logic                 accept;

  logic                 rsp_valid_q, zero_out, carry_out, ovf_out;
  logic [WORD_SIZE-1:0] field_out_q;

  assign bus.req_ready     = (state == IDLE) && reset;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.field_out     = field_out_q;
  assign bus.zero_flag     = zero_out;
  assign bus.carry_flag    = carry_out;
  assign bus.overflow_flag = ovf_out;

  // flush wins over a simultaneous handshake; the request is not taken.
  assign accept  = bus.req_valid && bus.req_ready && !bus.flush;
  assign eff_pos = clamp_pos(pos_q);
  assign cnt_nxt = cnt + POS_W'(1);
  // One extra bit so pos+len cannot wrap.
  assign span    = {1'b0, pos_q} + {1'b0, len_q};

  field_mask_gen u_mask (
    .len   (len_q),
    .data  (sh),
    .field (field_mask)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (bus.pos == '0) ? MASK : SHIFT;
      SHIFT: if (cnt_nxt == eff_pos) state_nxt = MASK;
      MASK:  state_nxt = DONE;
      DONE:  if (rsp_valid_q && bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples values from before the edge regardless of statement order.
  // NOTE: all registers, including datapath, are reset so no X escapes after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sh          <= '0;
      pos_q       <= '0;
      len_q       <= '0;
      cnt         <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      field_q     <= '0;
      rsp_valid_q <= 1'b0;
      field_out_q <= '0;
      zero_out    <= 1'b0;
      carry_out   <= 1'b0;
      ovf_out     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.flush) begin
        rsp_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            sh      <= bus.reg_in;
            pos_q   <= bus.pos;
            len_q   <= bus.len;
            cnt     <= '0;
            carry_q <= 1'b0;
          end
          SHIFT: begin
            sh      <= sh >> 1;
            carry_q <= sh[0];
            cnt     <= cnt_nxt;
          end
          MASK: begin
            field_q <= field_mask;
            zero_q  <= (field_mask == '0);
            ovf_q   <= (pos_q >= POS_W'(WORD_SIZE)) ||
                       (span > (POS_W + 1)'(WORD_SIZE));
          end
          DONE: begin
            if (!rsp_valid_q) begin
              rsp_valid_q <= 1'b1;
              field_out_q <= field_q;
              zero_out    <= zero_q;
              carry_out   <= carry_q;
              ovf_out     <= ovf_q;
            end else if (bus.rsp_ready) begin
              rsp_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_field_extract.sv
// Directed self-checking bench for bit_field_extract.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bit_field_extract;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit_field_extract_if bus ();

  bit_field_extract dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef SIGN_EXTEND_EN
  localparam logic [7:0] CASE1_FIELD = 8'hFD;
`else
  localparam logic [7:0] CASE1_FIELD = 8'h05;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request from a falling edge and returns on the falling edge
  // right after the accepting rising edge.
  task automatic send(input string tag, input logic [7:0] r, input logic [3:0] p,
                      input logic [3:0] l);
    bit taken = 1'b0;
    bus.reg_in    = r;
    bus.pos       = p;
    bus.len       = l;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      taken = bus.req_ready;
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check({tag, "_accepted"}, 32'(taken), 32'd1);
  endtask

  // Counts rising edges from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_rsp(input string tag, input logic [7:0] f, input logic z,
                           input logic c, input logic o);
    check({tag, "_field"}, 32'(bus.field_out), 32'(f));
    check({tag, "_zero"},  32'(bus.zero_flag), 32'(z));
    check({tag, "_carry"}, 32'(bus.carry_flag), 32'(c));
    check({tag, "_ovf"},   32'(bus.overflow_flag), 32'(o));
  endtask

  task automatic release_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_dropped"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int hits;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.reg_in    = '0;
    bus.pos       = '0;
    bus.len       = '0;

    // Reset state.
    #2;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_rsp("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // Case 1: B6, pos 2, len 3.
    send("c1", 8'hB6, 4'd2, 4'd3);
    check("c1_busy_ready", 32'(bus.req_ready), 32'd0);
    wait_rsp("c1", 4);
    check_rsp("c1", CASE1_FIELD, 1'b0, 1'b1, 1'b0);
    release_rsp("c1");

    // Case 2: F0, pos 5, len 4 (truncated).
    send("c2", 8'hF0, 4'd5, 4'd4);
    wait_rsp("c2", 7);
    check_rsp("c2", 8'h07, 1'b0, 1'b1, 1'b1);
    release_rsp("c2");

    // Case 3: FF, pos 0, len 0 (empty field, no shift).
    send("c3", 8'hFF, 4'd0, 4'd0);
    wait_rsp("c3", 2);
    check_rsp("c3", 8'h00, 1'b1, 1'b0, 1'b0);
    release_rsp("c3");

    // Case 4: 80, pos 9, len 2 (position clamped to 8 shifts).
    send("c4", 8'h80, 4'd9, 4'd2);
    wait_rsp("c4", 10);
    check_rsp("c4", 8'h00, 1'b1, 1'b1, 1'b1);
    release_rsp("c4");

    // Case 5: hold response for 3 cycles, then back-to-back request.
    send("c5", 8'hB6, 4'd2, 4'd3);
    wait_rsp("c5", 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("c5_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("c5_hold_ready", 32'(bus.req_ready), 32'd0);
      check_rsp("c5_hold", CASE1_FIELD, 1'b0, 1'b1, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.reg_in    = 8'hFF;
    bus.pos       = 4'd0;
    bus.len       = 4'd0;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("c5_xfer_valid", 32'(bus.rsp_valid), 32'd0);
    check("c5_b2b_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("c5_b2b_taken", 32'(bus.req_ready), 32'd0);
    wait_rsp("c5_b2b", 2);
    check_rsp("c5_b2b", 8'h00, 1'b1, 1'b0, 1'b0);
    release_rsp("c5_b2b");

    // Leave a nonzero result on the outputs before the reset test.
    send("c6pre", 8'hB6, 4'd2, 4'd3);
    wait_rsp("c6pre", 4);
    release_rsp("c6pre");

    // Case 6a: reset mid-SHIFT of case 2.
    send("c6", 8'hF0, 4'd5, 4'd4);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("c6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("c6_rst_ready", 32'(bus.req_ready), 32'd0);
    check_rsp("c6_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("c6_rel_ready", 32'(bus.req_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) hits++;
    end
    check("c6_no_partial", 32'(hits), 32'd0);

    // Case 6b: flush mid-SHIFT of case 2.
    send("c7", 8'hF0, 4'd5, 4'd4);
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("c7_flush_idle", 32'(bus.req_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) hits++;
    end
    check("c7_no_rsp", 32'(hits), 32'd0);

    // Flush in DONE with rsp_ready high discards the result.
    send("c8", 8'hF0, 4'd5, 4'd4);
    wait_rsp("c8", 7);
    bus.flush     = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    check("c8_flush_valid", 32'(bus.rsp_valid), 32'd0);
    check("c8_flush_ready", 32'(bus.req_ready), 32'd1);

    // Normal operation after flush.
    send("c9", 8'hB6, 4'd2, 4'd3);
    wait_rsp("c9", 4);
    check_rsp("c9", CASE1_FIELD, 1'b0, 1'b1, 1'b0);
    release_rsp("c9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
